// File: rtl/hog_stripe_sequencer.sv
// Stripe sequencer for the HOG accelerator's HP stream channels.
// The image is processed in stripes of rows. For each stripe the sequencer
// loads it from both S00 lanes into the core buffer, starts the core, waits
// for core_done, and then drains the result to both M00 lanes through a
// 2-entry output FIFO.
module hog_stripe_sequencer #(
  parameter int DATA_W   = 64,
  parameter int WIDTH_W  = 10,
  parameter int HEIGHT_W = 11,
  parameter int SROWS_W  = 6,
  parameter int BEAT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH_W-1:0]    cfg_width,
  input  logic [HEIGHT_W-1:0]   cfg_height,
  input  logic [SROWS_W-1:0]    cfg_stripe_rows,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [2*DATA_W-1:0]   s_tdata,
  input  logic [1:0]            s_tvalid,
  input  logic [1:0]            s_tlast,
  output logic [1:0]            s_tready,
  output logic [2*DATA_W-1:0]   m_tdata,
  output logic [1:0]            m_tvalid,
  output logic [1:0]            m_tlast,
  input  logic [1:0]            m_tready,
  output logic [2*DATA_W-1:0]   core_wdata,
  output logic                  core_wr_en,
  output logic                  core_start,
  input  logic                  core_done,
  output logic                  core_rd_en,
  input  logic [2*DATA_W-1:0]   core_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LOAD, S_PROC, S_WAIT, S_STORE, S_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH_W-1:0]  width_q;
  logic [HEIGHT_W-1:0] height_q;
  logic [SROWS_W-1:0]  srows_q;
  logic [HEIGHT_W-1:0] rows_left;
  logic [SROWS_W-1:0]  rows_stripe;
  logic [BEAT_W-1:0]   beats, last_beat, in_cnt, out_cnt, rd_left;
  logic                cfg_zero, in_beat, in_final, out_valid, out_beat, out_final;
  logic                stripe_last, rd_pending, push, pop_mem, wr_ptr, rd_ptr;
  logic [1:0]          fifo_cnt;
  logic [2*DATA_W-1:0] fifo_mem [2];
  logic [2*DATA_W-1:0] head_data;

  // The current stripe size follows rows_left, which only changes after the
  // final store beat, so it is stable for the whole load/process/store cycle.
  assign rows_stripe = (rows_left < HEIGHT_W'(srows_q)) ? rows_left[SROWS_W-1:0] : srows_q;
  assign beats       = BEAT_W'(width_q) * BEAT_W'(rows_stripe);
  assign last_beat   = beats - BEAT_W'(1);
  assign cfg_zero    = (width_q == '0) || (height_q == '0) || (srows_q == '0);
  assign stripe_last = (rows_left == HEIGHT_W'(rows_stripe));

  // Input side: a beat needs both lanes valid at once.
  assign in_beat    = (state == S_LOAD) && (&s_tvalid);
  assign in_final   = (in_cnt == last_beat);
  assign s_tready   = {2{in_beat}};
  assign core_wr_en = in_beat;
  assign core_wdata = s_tdata;

  // Output side: read data arriving this cycle is presented directly when the
  // FIFO is empty, which gives first m_tvalid two cycles after core_done.
  assign out_valid  = (fifo_cnt != 2'd0) || rd_pending;
  assign head_data  = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr]
                    : (rd_pending ? core_rdata : '0);
  assign out_beat   = out_valid && (&m_tready);
  assign out_final  = (out_cnt == last_beat);
  assign m_tvalid   = {2{out_valid}};
  assign m_tdata    = head_data;
  assign m_tlast    = {2{out_valid && out_final}};
  assign core_rd_en = (state == S_STORE) && (rd_left != '0) &&
                      ((fifo_cnt + {1'b0, rd_pending}) < 2'd2);
  assign push       = rd_pending && !(out_beat && (fifo_cnt == 2'd0));
  assign pop_mem    = out_beat && (fifo_cnt != 2'd0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic and state-decoded control outputs.
  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    core_start = 1'b0;
    case (state)
      S_IDLE:  if (start) state_next = S_CHECK;
      S_CHECK: state_next = cfg_zero ? S_DONE : S_LOAD;
      S_LOAD:  if (in_beat && in_final) state_next = S_PROC;
      S_PROC: begin
        core_start = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT:  if (core_done) state_next = S_STORE;
      S_STORE: if (out_beat && out_final) state_next = stripe_last ? S_DONE : S_LOAD;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Configuration latch, row bookkeeping, beat counters and the error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width_q   <= '0;
      height_q  <= '0;
      srows_q   <= '0;
      rows_left <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      rd_left   <= '0;
      err       <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        srows_q  <= cfg_stripe_rows;
        err      <= 1'b0;
      end
      if (state == S_CHECK) begin
        if (cfg_zero) err <= 1'b1;
        else          rows_left <= height_q;
      end
      if (in_beat) begin
        in_cnt <= in_final ? '0 : in_cnt + BEAT_W'(1);
        if (s_tlast != {2{in_final}}) err <= 1'b1;
      end
      if ((state == S_WAIT) && core_done) begin
        rd_left <= beats;
        out_cnt <= '0;
      end else if (core_rd_en) begin
        rd_left <= rd_left - BEAT_W'(1);
      end
      if (out_beat) begin
        out_cnt <= out_final ? '0 : out_cnt + BEAT_W'(1);
        if (out_final) rows_left <= rows_left - HEIGHT_W'(rows_stripe);
      end
    end
  end

  // Output FIFO pointers, occupancy and the in-flight read flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pending <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
    end else begin
      rd_pending <= core_rd_en;
      if (push)    wr_ptr <= ~wr_ptr;
      if (pop_mem) rd_ptr <= ~rd_ptr;
      case ({push, pop_mem})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; entries are only read while the occupancy marks them valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= core_rdata;
  end

endmodule

// File: tb/tb_hog_stripe_sequencer.sv
// Self-checking bench for hog_stripe_sequencer: table of runs, a core model
// feeding a scoreboard of expected output beats, and hand-written sequences
// for zero configuration and reset during store.
module tb_hog_stripe_sequencer;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   cfg_width = '0;
  logic [10:0]  cfg_height = '0;
  logic [5:0]   cfg_stripe_rows = '0;
  logic         busy, done, err;
  logic [127:0] s_tdata = '0;
  logic [1:0]   s_tvalid = '0, s_tlast = '0, s_tready;
  logic [127:0] m_tdata;
  logic [1:0]   m_tvalid, m_tlast;
  logic [1:0]   m_tready = '0;
  logic [127:0] core_wdata;
  logic         core_wr_en, core_start, core_rd_en;
  logic         core_done = 1'b0;
  logic [127:0] core_rdata = '0;

  always #5 clk = ~clk;

  hog_stripe_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_stripe_rows(cfg_stripe_rows),
    .busy(busy), .done(done), .err(err),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .core_wdata(core_wdata), .core_wr_en(core_wr_en), .core_start(core_start),
    .core_done(core_done), .core_rd_en(core_rd_en), .core_rdata(core_rdata)
  );

  typedef struct {
    int w; int h; int s;
    bit rnd;       // random valid/ready
    int tmode;     // 0 none, 1 early tlast on beat 5, 2 missing final tlast
    int nstr;      // expected core_start pulses
    int nbeats;    // expected beats in each direction
    bit xerr;      // expected err at done
  } vec_t;

  typedef struct { logic [127:0] d; bit last; } exp_t;

  vec_t   vecs[6];
  exp_t   sb[$];
  int     stripe_sz[$];
  int     n_vec = 0, n_err = 0;
  int     ld_stripe, ld_idx, rd_stripe, rd_idx;
  int     n_wr, n_cstart, n_done, n_out, n_rd, bad_ready, bad_wr;
  int     done_timer = 0;
  bit     rnd_mode = 0, rd_seen = 0, stalled = 0;
  int     tlast_mode = 0;
  logic [127:0] stall_data, rdata_seq = '0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_d(input string nm, input logic [129:0] act, input logic [129:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive stimulus and the core model just after each rising edge.
  always @(posedge clk) begin
    bit lastv;
    #1;
    core_done = 1'b0;
    if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) core_done = 1'b1;
    end
    if (rd_seen) begin
      rd_seen = 0;
      rdata_seq = rdata_seq + {$urandom, $urandom, $urandom, $urandom} + 128'd1;
      core_rdata = rdata_seq;
      lastv = (rd_stripe < stripe_sz.size()) && (rd_idx == stripe_sz[rd_stripe] - 1);
      sb.push_back('{d: core_rdata, last: lastv});
      rd_idx++;
      if (lastv) begin rd_idx = 0; rd_stripe++; end
    end
    s_tvalid = rnd_mode ? 2'($urandom_range(0, 3)) : 2'b11;
    s_tdata  = {$urandom, $urandom, $urandom, $urandom};
    lastv = (ld_stripe < stripe_sz.size()) && (ld_idx == stripe_sz[ld_stripe] - 1);
    if (tlast_mode == 1 && ld_stripe == 0 && ld_idx == 4) lastv = 1;
    if (tlast_mode == 2 && lastv) lastv = 0;
    s_tlast  = {2{lastv}};
    m_tready = rnd_mode ? 2'($urandom_range(0, 3)) : 2'b11;
  end

  // Observe the DUT on the falling edge; output beats are checked against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (&s_tready) begin
      n_wr++;
      ld_idx++;
      if (ld_stripe < stripe_sz.size() && ld_idx == stripe_sz[ld_stripe]) begin
        ld_idx = 0; ld_stripe++;
      end
    end
    if (s_tready != 2'b00 && s_tvalid != 2'b11) bad_ready++;
    if (core_wr_en && core_wdata !== s_tdata) bad_wr++;
    if (core_start) begin n_cstart++; done_timer = 3; end
    if (done) n_done++;
    if (core_rd_en) begin rd_seen = 1; n_rd++; end
    if (stalled) check_d("stall_hold", {m_tvalid, m_tdata}, {2'b11, stall_data});
    stalled = 0;
    if (m_tvalid == 2'b11) begin
      if (&m_tready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check_d("m_tdata", {2'b00, m_tdata}, {2'b00, e.d});
          check("m_tlast", m_tlast, {2{e.last}});
        end
      end else begin
        stalled = 1;
        stall_data = m_tdata;
      end
    end
  end

  task automatic start_run(input vec_t v);
    int rem, rs;
    stripe_sz.delete();
    rem = v.h;
    while (rem > 0) begin
      rs = (rem < v.s) ? rem : v.s;
      stripe_sz.push_back(v.w * rs);
      rem -= rs;
    end
    ld_stripe = 0; ld_idx = 0; rd_stripe = 0; rd_idx = 0;
    rnd_mode = v.rnd; tlast_mode = v.tmode;
    n_wr = 0; n_cstart = 0; n_done = 0; n_out = 0; n_rd = 0; bad_ready = 0; bad_wr = 0;
    @(posedge clk); #2;
    cfg_width = 10'(v.w); cfg_height = 11'(v.h); cfg_stripe_rows = 6'(v.s);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    check("busy_t1", busy, 1);
  endtask

  task automatic finish_run(input vec_t v, input bit extra_start);
    bit seen = 0;
    if (extra_start) begin
      repeat (5) @(posedge clk);
      #2 cfg_width = 10'd1; cfg_height = 11'd1; cfg_stripe_rows = 6'd1; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
    end
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    check("done_seen", seen, 1);
    check("err_at_done", err, v.xerr);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_pulses", n_done, 1);
    check("core_starts", n_cstart, v.nstr);
    check("in_beats", n_wr, v.nbeats);
    check("rd_reqs", n_rd, v.nbeats);
    check("out_beats", n_out, v.nbeats);
    check("sb_empty", sb.size(), 0);
    check("ready_no_valid", bad_ready, 0);
    check("wdata_pass", bad_wr, 0);
  endtask

  initial begin
    vec_t zv;
    bit reached;
    vecs[0] = '{4, 8, 4, 0, 0, 2, 32, 0};
    vecs[1] = '{3, 10, 4, 0, 0, 3, 30, 0};
    vecs[2] = '{5, 7, 3, 1, 0, 3, 35, 0};
    vecs[3] = '{4, 4, 4, 0, 1, 1, 16, 1};
    vecs[4] = '{4, 4, 4, 0, 2, 1, 16, 1};
    vecs[5] = '{1, 1, 63, 1, 0, 1, 1, 0};

    repeat (3) @(posedge clk);
    #2;
    check("reset_ctrl", {busy, done, err, s_tready, m_tvalid, m_tlast, core_start, core_rd_en, core_wr_en}, 0);
    check_d("reset_mdata", {2'b00, m_tdata}, 130'd0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_run(vecs[i]);
      finish_run(vecs[i], 1'b0);
    end

    // Zero width: done two cycles after start, nothing transferred.
    zv = '{0, 8, 4, 0, 0, 0, 0, 1};
    start_run(zv);
    @(negedge clk);
    check("zero_done_t2", done, 1);
    check("zero_err_t2", err, 1);
    repeat (3) @(negedge clk);
    check("zero_busy", busy, 0);
    check("zero_no_ready", n_wr, 0);
    check("zero_no_cstart", n_cstart, 0);
    check("zero_no_rd", n_rd, 0);

    // Reset while storing; outputs clear at once, then a clean rerun.
    start_run(vecs[0]);
    reached = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_out >= 7) begin reached = 1; break; end
    end
    check("reach_store_beat7", reached, 1);
    rst = 1'b0;
    #1;
    check("midrst_ctrl", {busy, done, err, s_tready, m_tvalid, m_tlast, core_start, core_rd_en, core_wr_en}, 0);
    check_d("midrst_mdata", {2'b00, m_tdata}, 130'd0);
    repeat (2) @(posedge clk);
    #3;
    sb.delete(); rd_seen = 0; done_timer = 0; stalled = 0; core_done = 1'b0;
    @(negedge clk) rst = 1'b1;
    start_run(vecs[0]);
    finish_run(vecs[0], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hog_stripe_sequencer.md
# hog_stripe_sequencer

Sequencer for the HOG accelerator's two high-performance AXI-Stream channels (HP0, HP1). On a start command it processes the image one stripe (a group of rows) at a time:
- loads a stripe from DDR through both S00 stream lanes into the core buffer;
- starts the core and waits for it to finish;
- drains the result back to DDR through both M00 lanes.

It sits between the HP stream ports and the HOG core. Its configuration inputs are driven by the AXI-Lite GP register bank.

## Interface
- DATA_W, 64, width of each stream lane (matches the 64-bit HP stream data).
- WIDTH_W, 10, width of cfg_width.
- HEIGHT_W, 11, width of cfg_height.
- SROWS_W, 6, width of cfg_stripe_rows.
- BEAT_W, 16, width of the per-stripe beat counter.
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- cfg_width  in  WIDTH_W  64-bit words per row, per lane.
- cfg_height  in  HEIGHT_W  total image rows.
- cfg_stripe_rows  in  SROWS_W  rows per stripe.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag; cleared by the next accepted start.
- s_tdata  in  2*DATA_W  HP1 lane in the upper half, HP0 in the lower half.
- s_tvalid, s_tlast  in  2  per-lane input stream controls.
- s_tready  out  2  per-lane input ready.
- m_tdata  out  2*DATA_W  output data, same lane packing as s_tdata.
- m_tvalid, m_tlast  out  2  per-lane output stream controls.
- m_tready  in  2  per-lane output ready.
- core_wdata  out  2*DATA_W  equals s_tdata.
- core_wr_en  out  1  write strobe into the core buffer.
- core_start  out  1  one-cycle pulse that starts processing of the loaded stripe.
- core_done  in  1  one-cycle pulse when the core has finished the stripe.
- core_rd_en  out  1  read request to the core; data returns one cycle later.
- core_rdata  in  2*DATA_W  core read data.

## Operation
- States: IDLE, CHECK, LOAD, PROC, WAIT, STORE, DONE.
- IDLE, on start:
  - latch the three cfg_* inputs;
  - clear err;
  - go to CHECK.
- CHECK:
  - if any latched cfg_* value is 0: set err and go to DONE. No stream beats are transferred.
  - otherwise set rows_left = cfg_height and go to LOAD.
- Stripe size at entry to LOAD:
  - rows_stripe = min(cfg_stripe_rows, rows_left);
  - beats = cfg_width * rows_stripe, computed unsigned into BEAT_W bits (maximum 1023*63 = 64449, fits).
- LOAD:
  - s_tready = {2{&s_tvalid}}; a beat occurs only when both lanes are valid.
  - core_wr_en = beat; core_wdata = s_tdata.
  - Beat counter counts up to beats. The final beat goes to PROC.
  - tlast check: any s_tlast bit differing from (beat == final) sets err. Transfer continues; no abort.
- PROC: core_start = 1 for exactly one cycle, then go to WAIT.
- WAIT: on core_done, go to STORE. core_done in any other state is ignored.
- STORE (output path):
  - 2-entry output FIFO; core_rd_en is asserted only when FIFO occupancy plus the in-flight read is below 2, and reads remaining > 0.
  - m_tvalid = {2{FIFO not empty}}; an output beat occurs when m_tvalid and &m_tready.
  - m_tlast = {2{head entry is the stripe's final beat}}.
  - m_tvalid never depends on m_tready; data stays stable while stalled.
- After the final STORE beat, rows_left -= rows_stripe:
  - if rows_left > 0, go to LOAD;
  - otherwise go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- start received while not in IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- Reset asserted mid-operation: immediate return to IDLE. No done pulse; err cleared; in-flight core data discarded.
- start at cycle t: busy = 1 at t+1 (CHECK); LOAD from t+2.
- LOAD throughput is one beat per cycle when both lanes are valid.
- The final LOAD beat at cycle c gives core_start = 1 at c+1.
- core_done at cycle d gives the first core_rd_en at d+1 and the first m_tvalid at d+2.
- STORE sustains one beat per cycle when m_tready is held high.
- Final STORE beat at cycle e:
  - next stripe: LOAD at e+1;
  - last stripe: done = 1 at e+1, busy = 0 at e+2.
- Config error: start at t gives done at t+2, with err = 1 from t+2.

## Test plan
- Basic run: width=4, height=8, stripe_rows=4, streams always valid/ready -> 2 stripes of 16 beats each; two core_start pulses; m_tlast on output beats 16 and 32; a single done pulse; err = 0.
- Short last stripe: width=3, height=10, stripe_rows=4 -> stripes of 12, 12 and 6 beats; done after the third stripe's store.
- Backpressure: random s_tvalid per lane and random m_tready -> no beat taken unless both lanes are ready/valid; m_tdata stable while stalled; output equals core_rdata in order.
- tlast errors:
  - s_tlast asserted on beat 5 of 16 -> err = 1, run completes, done pulses;
  - s_tlast missing on the final beat -> err = 1.
- Zero config: cfg_width=0 -> done at t+2, err = 1; s_tready, core_start and core_rd_en never asserted.
- Reset mid-STORE: assert rst at beat 7 -> all outputs 0 immediately; a new start runs a clean full transfer; a start issued while busy is ignored.
